mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised successor to the single-client memory controller.
- Arbitrates NUM_CH client channels (e.g. instruction fetch, load, store) onto the byte-serial RAM/IO port.
- Each access is 1, 2 or 4 bytes, little-endian, read or write. Reads are assembled into a 32-bit word.
- Adds round-robin fairness, an IO-buffer-full write stall, and a per-channel read flush.

Parameters:
- NUM_CH, 3, number of client channels (2..8).
- FLUSH_MASK, 3'b011, NUM_CH bits; bit i=1 lets flush abort an in-flight read of channel i.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes the block.
- flush  in  1  abort in-flight read of a FLUSH_MASK channel.
- io_buffer_full  in  1  UART tx buffer full.
- mem_din  in  8  RAM/IO read byte, valid the cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write this cycle.
- ch_req  in  NUM_CH  per-channel request, held until done.
- ch_wr  in  NUM_CH  1 = write.
- ch_len  in  2*NUM_CH  00=1B, 01=2B, 10=4B, 11 treated as 4B.
- ch_addr  in  32*NUM_CH  start byte address.
- ch_wdata  in  32*NUM_CH  write data, low byte first.
- ch_done  out  NUM_CH  one-cycle completion pulse.
- ch_rdata  out  32  read word, zero-extended, valid while the matching ch_done is high.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; mem_a=0, mem_dout=0, mem_wr=0, ch_done=0, ch_rdata=0.
  - Round-robin pointer=0.
- All outputs are registered.
- rdy low: all registers hold, except mem_wr, which is forced 0 while rdy is low. Operation resumes unchanged when rdy returns.
- States: IDLE, READ, WRITE.
- IDLE:
  - At an edge where any ch_req is set, grant the first requester at or after the pointer (wrapping).
  - Latch wr, n = 1/2/4, addr and wdata. Set pointer = grant+1 mod NUM_CH.
  - Go to READ or WRITE. The first byte address/data is driven at that same edge.
- WRITE:
  - Byte k (k=0..n-1) is driven for one cycle: mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - On the edge after the last byte: ch_done[grant]=1 for one cycle, mem_wr=0, return to IDLE.
  - An n-byte write with no stall gives done n cycles after the grant edge.
- IO stall (writes only): if addr[17:16]==2'b11 and io_buffer_full=1 when a byte is to be issued:
  - drive mem_wr=0 and keep the same byte pending;
  - retry each cycle until io_buffer_full=0.
- READ:
  - mem_a=addr+k for k=0..n-1 on consecutive cycles, mem_wr=0.
  - mem_din is captured one cycle later into rdata byte k.
  - On the capture edge of the last byte: ch_done[grant]=1, ch_rdata=assembled word with upper bytes 0, return to IDLE.
  - Latency is n+1 cycles from the grant edge.
  - No IO stall applies to reads.
- Turnaround: one IDLE cycle always follows done before the next grant.
- flush:
  - Sampled every edge.
  - Aborts only a READ whose grant channel has its FLUSH_MASK bit set. Result: return to IDLE, no ch_done, captured bytes discarded, mem_a=0.
  - Also suppresses new grants to masked channels at that edge.
  - Never aborts a WRITE, and never affects unmasked channels.
- Address arithmetic is 32-bit, wrapping; no alignment check.
- A requester that drops ch_req before done (other than via flush) is a protocol violation; behaviour is undefined.
- Grant and ch_done never occur in the same cycle for the same channel.

Test Plan:
- Reset, then ch_req[0]=1, 4B read @0x100, RAM holds 11 22 33 44 -> mem_a 0x100..0x103 on 4 consecutive cycles; ch_done[0] 5 cycles after grant; ch_rdata=0x44332211.
- ch_req[2]=1, 2B write @0x200, wdata=0xAABBCCDD -> mem_wr=1 with (0x200,DD) then (0x201,CC); ch_done[2] 2 cycles after grant; RAM[0x202] untouched.
- ch_req=3'b111 held continuously, each 1B read -> grants in order 0,1,2,0,1,2; exactly one IDLE cycle between each done and the next grant.
- 1B write @0x30000, data 0x41, io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write cycle; done one cycle after that write.
- Channel 1 4B read, flush pulsed after the second byte is captured -> no ch_done[1]; IDLE next cycle. Repeat with a channel 2 write -> the write completes normally.
- rdy low for 4 cycles mid 4B read -> mem_a frozen, mem_wr=0; after resume, rdata and latency (excluding frozen cycles) are identical to the unpaused case. Reset asserted mid-transfer -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises NUM_CH 1/2/4-byte client accesses onto a
// byte-wide RAM/IO port, with IO write stall and per-channel read flush.
module mem_arbiter #(
    parameter int                NUM_CH     = 3,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = 3'b011
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [NUM_CH-1:0]     ch_wr,
    input  logic [2*NUM_CH-1:0]   ch_len,
    input  logic [32*NUM_CH-1:0]  ch_addr,
    input  logic [32*NUM_CH-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]     ch_done,
    output logic [31:0]           ch_rdata
);
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            r_state,    w_state_nxt;
    logic [CW-1:0]     r_ptr,      w_ptr_nxt;
    logic [CW-1:0]     r_gnt,      w_gnt_nxt;
    logic [2:0]        r_len,      w_len_nxt;
    logic [2:0]        r_step,     w_step_nxt;
    logic [31:0]       r_addr,     w_addr_nxt;
    logic [31:0]       r_wdata,    w_wdata_nxt;
    logic [31:0]       r_rbuf,     w_rbuf_nxt;
    logic [31:0]       r_mem_a,    w_mem_a_nxt;
    logic [7:0]        r_mem_dout, w_mem_dout_nxt;
    logic              r_mem_wr,   w_mem_wr_nxt;
    logic [NUM_CH-1:0] r_done,     w_done_nxt;
    logic [31:0]       r_rdata,    w_rdata_nxt;

    logic [NUM_CH-1:0] w_elig;
    logic              w_found;
    logic [CW-1:0]     w_gnt;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [1:0]        w_sel_len;
    logic [2:0]        w_step_inc;
    logic [31:0]       w_next_a;
    logic [1:0]        w_cap_idx;
    logic [1:0]        w_wr_idx;
    logic [31:0]       w_cap;

    function automatic logic io_stall(input logic [31:0] a, input logic full);
        return (a[17:16] == 2'b11) && full;
    endfunction

    // A channel whose done is still showing cannot be re-granted in the same cycle.
    assign w_elig = ch_req & ~r_done & ~(flush ? FLUSH_MASK : '0);

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && w_elig[(int'(r_ptr) + i) % NUM_CH]) begin
                w_found = 1'b1;
                w_gnt   = CW'((int'(r_ptr) + i) % NUM_CH);
            end
        end
    end

    assign w_sel_addr  = ch_addr[32*int'(w_gnt) +: 32];
    assign w_sel_wdata = ch_wdata[32*int'(w_gnt) +: 32];
    assign w_sel_len   = ch_len[2*int'(w_gnt) +: 2];
    assign w_step_inc  = r_step + 3'd1;
    assign w_next_a    = r_addr + {29'd0, w_step_inc};
    assign w_cap_idx   = 2'(r_step - 3'd1);
    assign w_wr_idx    = 2'(w_step_inc);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_gnt_nxt      = r_gnt;
        w_len_nxt      = r_len;
        w_step_nxt     = r_step;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_rbuf_nxt     = r_rbuf;
        w_mem_a_nxt    = r_mem_a;
        w_mem_dout_nxt = r_mem_dout;
        w_mem_wr_nxt   = 1'b0;
        w_done_nxt     = '0;
        w_rdata_nxt    = r_rdata;
        w_cap          = r_rbuf;
        w_cap[{w_cap_idx, 3'b000} +: 8] = mem_din;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = w_gnt;
                    w_ptr_nxt   = (w_gnt == CW'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
                    w_len_nxt   = (w_sel_len == 2'b00) ? 3'd1 : (w_sel_len == 2'b01) ? 3'd2 : 3'd4;
                    w_addr_nxt  = w_sel_addr;
                    w_wdata_nxt = w_sel_wdata;
                    w_step_nxt  = '0;
                    w_rbuf_nxt  = '0;
                    w_mem_a_nxt = w_sel_addr;
                    if (ch_wr[w_gnt]) begin
                        w_state_nxt    = WRITE;
                        w_mem_dout_nxt = w_sel_wdata[7:0];
                        w_mem_wr_nxt   = !io_stall(w_sel_addr, io_buffer_full);
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                // r_mem_wr records whether the pending byte actually went out last cycle.
                if (r_mem_wr) begin
                    if (w_step_inc == r_len) begin
                        w_done_nxt[r_gnt] = 1'b1;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_step_nxt     = w_step_inc;
                        w_mem_a_nxt    = w_next_a;
                        w_mem_dout_nxt = r_wdata[{w_wr_idx, 3'b000} +: 8];
                        w_mem_wr_nxt   = !io_stall(w_next_a, io_buffer_full);
                    end
                end else begin
                    w_mem_wr_nxt = !io_stall(r_mem_a, io_buffer_full);
                end
            end
            READ: begin
                if (flush && FLUSH_MASK[r_gnt]) begin
                    w_state_nxt = IDLE;
                    w_mem_a_nxt = '0;
                    w_rbuf_nxt  = '0;
                end else begin
                    if (r_step != 3'd0) w_rbuf_nxt = w_cap;
                    if (r_step == r_len) begin
                        w_done_nxt[r_gnt] = 1'b1;
                        w_rdata_nxt       = w_cap;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_step_nxt = w_step_inc;
                        if (w_step_inc < r_len) w_mem_a_nxt = w_next_a;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_len      <= '0;
            r_step     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_done     <= '0;
            r_rdata    <= '0;
        end else if (rdy) begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_len      <= w_len_nxt;
            r_step     <= w_step_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rbuf     <= w_rbuf_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_done     <= w_done_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

    // Write strobe is masked while frozen so a held byte is never written twice.
    assign mem_wr   = r_mem_wr & rdy;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign ch_done  = r_done;
    assign ch_rdata = r_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-wide RAM model that
// returns data the cycle after its address and honours rdy.
module tb_mem_arbiter;
    localparam int NUM_CH = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rdy;
    logic                 flush;
    logic                 io_buffer_full;
    logic [7:0]           mem_din;
    logic [7:0]           mem_dout;
    logic [31:0]          mem_a;
    logic                 mem_wr;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_wr;
    logic [2*NUM_CH-1:0]  ch_len;
    logic [32*NUM_CH-1:0] ch_addr;
    logic [32*NUM_CH-1:0] ch_wdata;
    logic [NUM_CH-1:0]    ch_done;
    logic [31:0]          ch_rdata;

    logic [7:0] ram [0:4095];
    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.NUM_CH(NUM_CH), .FLUSH_MASK(3'b011)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_len(ch_len), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_done(ch_done), .ch_rdata(ch_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
            ram[12'h202] <= 8'h5A;
            mem_din      <= 8'h00;
        end else if (rdy) begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [1:0] len,
                          input logic [31:0] a, input logic [31:0] d);
        ch_wr[ch]            = wr;
        ch_len[2*ch +: 2]    = len;
        ch_addr[32*ch +: 32] = a;
        ch_wdata[32*ch +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        ch_req = '0; ch_wr = '0; ch_len = '0; ch_addr = '0; ch_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_cmp++; if (mem_dout !== 8'h0) begin n_err++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        n_cmp++; if (ch_done !== 3'b000) begin n_err++; $display("FAIL reset_done: got %b want 000", ch_done); end
        n_cmp++; if (ch_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", ch_rdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read4();
        logic [2:0] exp_done;
        set_ch(0, 1'b0, 2'b10, 32'h100, 32'h0);
        ch_req = 3'b001;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                n_cmp++; if (mem_a !== 32'h100 + k) begin n_err++; $display("FAIL rd4_addr%0d: got %h want %h", k, mem_a, 32'h100 + k); end
            end
            exp_done = (k == 5) ? 3'b001 : 3'b000;
            n_cmp++; if (ch_done !== exp_done) begin n_err++; $display("FAIL rd4_done_c%0d: got %b want %b", k, ch_done, exp_done); end
        end
        n_cmp++; if (ch_rdata !== 32'h44332211) begin n_err++; $display("FAIL rd4_rdata: got %h want 44332211", ch_rdata); end
        ch_req = '0;
        tick();
    endtask

    task automatic test_write2();
        set_ch(2, 1'b1, 2'b01, 32'h200, 32'hAABBCCDD);
        ch_req = 3'b100;
        tick();
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200, 8'hDD}) begin n_err++; $display("FAIL wr2_b0: got %b %h %h want 1 200 dd", mem_wr, mem_a, mem_dout); end
        tick();
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h201, 8'hCC}) begin n_err++; $display("FAIL wr2_b1: got %b %h %h want 1 201 cc", mem_wr, mem_a, mem_dout); end
        n_cmp++; if (ch_done !== 3'b000) begin n_err++; $display("FAIL wr2_early_done: got %b want 000", ch_done); end
        tick();
        n_cmp++; if ({ch_done, mem_wr} !== {3'b100, 1'b0}) begin n_err++; $display("FAIL wr2_done: got %b %b want 100 0", ch_done, mem_wr); end
        ch_req = '0;
        tick();
        n_cmp++; if ({ram[12'h200], ram[12'h201], ram[12'h202]} !== 24'hDDCC5A) begin n_err++; $display("FAIL wr2_ram: got %h want ddcc5a", {ram[12'h200], ram[12'h201], ram[12'h202]}); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_done;
        logic [31:0] exp_a;
        set_ch(0, 1'b0, 2'b00, 32'h10, 32'h0);
        set_ch(1, 1'b0, 2'b00, 32'h20, 32'h0);
        set_ch(2, 1'b0, 2'b00, 32'h30, 32'h0);
        ch_req = 3'b111;
        for (int j = 0; j < 18; j++) begin
            tick();
            exp_done = (j % 3 == 2) ? 3'(1 << ((j / 3) % 3)) : 3'b000;
            n_cmp++; if (ch_done !== exp_done) begin n_err++; $display("FAIL rr_done_c%0d: got %b want %b", j, ch_done, exp_done); end
            if (j % 3 == 0) begin
                exp_a = 32'h10 * (((j / 3) % 3) + 1);
                n_cmp++; if (mem_a !== exp_a) begin n_err++; $display("FAIL rr_grant_c%0d: got %h want %h", j, mem_a, exp_a); end
            end
        end
        ch_req = '0;
        tick();
    endtask

    task automatic test_io_stall();
        io_buffer_full = 1'b1;
        set_ch(0, 1'b1, 2'b00, 32'h30000, 32'h41);
        ch_req = 3'b001;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if ({mem_wr, mem_a, ch_done} !== {1'b0, 32'h30000, 3'b000}) begin n_err++; $display("FAIL io_stall_c%0d: got %b %h %b want 0 30000 000", k, mem_wr, mem_a, ch_done); end
        end
        io_buffer_full = 1'b0;
        tick();
        n_cmp++; if ({mem_wr, mem_dout, ch_done} !== {1'b1, 8'h41, 3'b000}) begin n_err++; $display("FAIL io_issue: got %b %h %b want 1 41 000", mem_wr, mem_dout, ch_done); end
        tick();
        n_cmp++; if ({mem_wr, ch_done} !== {1'b0, 3'b001}) begin n_err++; $display("FAIL io_done: got %b %b want 0 001", mem_wr, ch_done); end
        ch_req = '0;
        tick();
    endtask

    task automatic test_flush();
        set_ch(1, 1'b0, 2'b10, 32'h100, 32'h0);
        ch_req = 3'b010;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if ({mem_a, ch_done} !== {32'h100 + k, 3'b000}) begin n_err++; $display("FAIL fl_rd_c%0d: got %h %b want %h 000", k, mem_a, ch_done, 32'h100 + k); end
        end
        flush = 1'b1;
        tick();
        n_cmp++; if ({mem_a, mem_wr, ch_done} !== {32'h0, 1'b0, 3'b000}) begin n_err++; $display("FAIL fl_abort: got %h %b %b want 0 0 000", mem_a, mem_wr, ch_done); end
        flush = 1'b0;
        ch_req = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if ({mem_a, ch_done} !== {32'h0, 3'b000}) begin n_err++; $display("FAIL fl_idle_c%0d: got %h %b want 0 000", k, mem_a, ch_done); end
        end
        // write on an unmasked channel runs to completion through a flush pulse
        set_ch(2, 1'b1, 2'b01, 32'h208, 32'h12345678);
        ch_req = 3'b100;
        tick();
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h208, 8'h78}) begin n_err++; $display("FAIL flw_b0: got %b %h %h want 1 208 78", mem_wr, mem_a, mem_dout); end
        flush = 1'b1;
        tick();
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h209, 8'h56}) begin n_err++; $display("FAIL flw_b1: got %b %h %h want 1 209 56", mem_wr, mem_a, mem_dout); end
        flush = 1'b0;
        tick();
        n_cmp++; if (ch_done !== 3'b100) begin n_err++; $display("FAIL flw_done: got %b want 100", ch_done); end
        ch_req = '0;
        tick();
        n_cmp++; if ({ram[12'h208], ram[12'h209]} !== 16'h7856) begin n_err++; $display("FAIL flw_ram: got %h want 7856", {ram[12'h208], ram[12'h209]}); end
        // flush at a grant edge skips masked ch0 and grants unmasked ch2
        set_ch(0, 1'b0, 2'b00, 32'h10, 32'h0);
        set_ch(2, 1'b0, 2'b00, 32'h30, 32'h0);
        ch_req = 3'b101;
        flush = 1'b1;
        tick();
        n_cmp++; if (mem_a !== 32'h30) begin n_err++; $display("FAIL fl_suppress: got %h want 30", mem_a); end
        flush = 1'b0;
        tick();
        tick();
        n_cmp++; if (ch_done !== 3'b100) begin n_err++; $display("FAIL fl_sup_done2: got %b want 100", ch_done); end
        ch_req = 3'b001;
        tick();
        n_cmp++; if ({mem_a, ch_done} !== {32'h10, 3'b000}) begin n_err++; $display("FAIL fl_sup_grant0: got %h %b want 10 000", mem_a, ch_done); end
        tick();
        tick();
        n_cmp++; if (ch_done !== 3'b001) begin n_err++; $display("FAIL fl_sup_done0: got %b want 001", ch_done); end
        ch_req = '0;
        tick();
    endtask

    task automatic test_rdy_pause();
        set_ch(0, 1'b0, 2'b10, 32'h100, 32'h0);
        ch_req = 3'b001;
        tick();
        tick();
        n_cmp++; if (mem_a !== 32'h101) begin n_err++; $display("FAIL rdy_pre: got %h want 101", mem_a); end
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if ({mem_a, mem_wr, ch_done} !== {32'h101, 1'b0, 3'b000}) begin n_err++; $display("FAIL rdy_frozen_c%0d: got %h %b %b want 101 0 000", k, mem_a, mem_wr, ch_done); end
        end
        rdy = 1'b1;
        tick();
        n_cmp++; if (mem_a !== 32'h102) begin n_err++; $display("FAIL rdy_resume2: got %h want 102", mem_a); end
        tick();
        n_cmp++; if (mem_a !== 32'h103) begin n_err++; $display("FAIL rdy_resume3: got %h want 103", mem_a); end
        tick();
        n_cmp++; if (ch_done !== 3'b000) begin n_err++; $display("FAIL rdy_early_done: got %b want 000", ch_done); end
        tick();
        n_cmp++; if ({ch_done, ch_rdata} !== {3'b001, 32'h44332211}) begin n_err++; $display("FAIL rdy_done: got %b %h want 001 44332211", ch_done, ch_rdata); end
        ch_req = '0;
        tick();
        // write strobe drops as soon as rdy falls and returns with rdy
        set_ch(1, 1'b1, 2'b00, 32'h210, 32'h99);
        ch_req = 3'b010;
        tick();
        n_cmp++; if (mem_wr !== 1'b1) begin n_err++; $display("FAIL rdyw_issue: got %b want 1", mem_wr); end
        rdy = 1'b0;
        #1;
        n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL rdyw_forced: got %b want 0", mem_wr); end
        tick();
        tick();
        n_cmp++; if ({mem_wr, ch_done} !== {1'b0, 3'b000}) begin n_err++; $display("FAIL rdyw_hold: got %b %b want 0 000", mem_wr, ch_done); end
        rdy = 1'b1;
        #1;
        n_cmp++; if ({mem_wr, mem_dout} !== {1'b1, 8'h99}) begin n_err++; $display("FAIL rdyw_resume: got %b %h want 1 99", mem_wr, mem_dout); end
        tick();
        n_cmp++; if ({ch_done, mem_wr} !== {3'b010, 1'b0}) begin n_err++; $display("FAIL rdyw_done: got %b %b want 010 0", ch_done, mem_wr); end
        ch_req = '0;
        tick();
        n_cmp++; if (ram[12'h210] !== 8'h99) begin n_err++; $display("FAIL rdyw_ram: got %h want 99", ram[12'h210]); end
    endtask

    task automatic test_async_reset();
        set_ch(2, 1'b0, 2'b10, 32'h100, 32'h0);
        ch_req = 3'b100;
        tick();
        tick();
        n_cmp++; if (mem_a !== 32'h101) begin n_err++; $display("FAIL ar_pre: got %h want 101", mem_a); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({mem_a, mem_dout, mem_wr, ch_done, ch_rdata} !== 76'h0) begin n_err++; $display("FAIL ar_outputs: got %h %h %b %b %h want all 0", mem_a, mem_dout, mem_wr, ch_done, ch_rdata); end
        ch_req = '0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_read4();
        test_write2();
        test_round_robin();
        test_io_stall();
        test_flush();
        test_rdy_pause();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
